spi_master_core: RTL and testbench
==================================

Name: spi_master_core

Overview:
- Transmit/receive engine for the SPI master side; consumes the tx byte, 32-bit master config word and trans_en start strobe, and produces the rx byte and interrupt.
- Drives SCLK/MOSI/CS_n toward the slave and samples MISO; one transfer of DATA_W bits per start.
- Sits directly downstream of the register/driver stage that supplies data_config_master and i_data_m.

Parameters:
DATA_W, 8, bits per transfer (shift register and data port width)
CFG_W, 32, config word width; only bits [11:0] used

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_data  input  DATA_W  tx byte, latched at start
data_config  input  CFG_W  [7:0] DIV, [8] CPOL, [9] CPHA, [10] LSB_FIRST, [11] IRQ_EN, [31:12] ignored; latched at start
trans_en  input  1  start strobe, sampled on clk rising edge
irq_clr  input  1  clears interupt_request
o_data  output  DATA_W  last received byte
interupt_request  output  1  sticky completion interrupt
busy  output  1  transfer in progress
done  output  1  one-cycle completion pulse
spi_sclk  output  1  serial clock
spi_mosi  output  1  serial data out
spi_miso  input  1  serial data in
spi_cs_n  output  1  active-low chip select

Behaviour:
- Reset (async, immediate): state IDLE, o_data=0, interupt_request=0, busy=0, done=0, spi_sclk=0, spi_mosi=0, spi_cs_n=1, latched config=0, bit counter=0.
- Half-period H = DIV+1 clk cycles (DIV=0 gives H=1); divider counter 8 bits, reloads at each half-period end.
- FSM IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE.
- IDLE: cs_n=1, sclk=latched CPOL. trans_en=1 at an edge: latch i_data and config, busy=1, cs_n=0, go LEAD. trans_en ignored in any other state (no queuing).
- LEAD: lasts H cycles. CPHA=0: first tx bit on mosi at LEAD entry. Then go SHIFT.
- SHIFT: 2*DATA_W sclk toggles, one per half-period end; odd toggles are leading edges, even toggles trailing.
- CPHA=0: sample miso on leading edge; shift next tx bit to mosi on trailing edge (no shift after the last).
- CPHA=1: drive tx bit on leading edge (first bit at first leading edge); sample miso on trailing edge.
- Bit order: MSB first unless LSB_FIRST=1; applies to tx and rx. rx assembled so o_data[DATA_W-1] is the first bit received when MSB first.
- After the 2*DATA_W-th toggle sclk equals CPOL; go TRAIL.
- TRAIL: cs_n held 0 for H cycles. At its end: cs_n=1, o_data <= rx shift reg, done=1 for one cycle, busy=0, interupt_request=1 if IRQ_EN, go IDLE.
- Latency: trans_en sampled at edge N -> done/o_data/busy fall visible after edge N+(2*DATA_W+2)*H; DATA_W=8, DIV=1 -> 36 cycles.
- Earliest restart: trans_en in the cycle done=1 is accepted (state already IDLE).
- interupt_request: sticky until irq_clr=1. Set and clear in same cycle: set wins. irq_clr while low: no effect.
- o_data holds between transfers; changes only at TRAIL end.
- Config/i_data changes after start do not affect the active transfer.
- Reset mid-transfer: transfer aborted, cs_n=1 immediately, o_data not updated (returns to 0), no done/interrupt.
- mosi holds last driven bit outside SHIFT/LEAD; 0 after reset.

Test Plan:
- Loopback mosi->miso, config=0x0000_0801 (DIV=1, mode 0, IRQ_EN), i_data=0xA5 -> mosi bits 1,0,1,0,0,1,0,1 sampled on rising sclk; o_data=0xA5, done pulse 36 cycles after start, interupt_request=1.
- Mode 3 (config=0x0000_0300), slave model returns 0x3C on falling edges -> sclk idles 1, o_data=0x3C, interupt_request stays 0, total 18 cycles with DIV=0.
- LSB_FIRST (config=0x0000_0400), i_data=0x01, loopback -> first mosi bit 1, remaining 0; o_data=0x01.
- trans_en pulsed again at cycles 5 and 20 of an active transfer -> ignored; exactly one done pulse; new trans_en in the done cycle starts a second transfer immediately.
- rst asserted mid-SHIFT (cycle 10, asynchronous to clk edge) -> cs_n=1, busy=0, sclk=0 immediately; o_data=0; no done; a later start completes normally.
- interupt_request high, irq_clr asserted in the same cycle a new transfer completes with IRQ_EN=1 -> interupt_request stays 1; irq_clr next cycle -> 0.

Source files
------------

// File: rtl/spi_master_core.sv
// SPI master transmit/receive engine: one DATA_W-bit full-duplex transfer per start strobe,
// with programmable SCLK half-period, CPOL/CPHA, bit order and a sticky completion interrupt.
module spi_master_core #(
  parameter int DATA_W = 8,
  parameter int CFG_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CFG_W-1:0]  data_config,
  input  logic              trans_en,
  input  logic              irq_clr,
  output logic [DATA_W-1:0] o_data,
  output logic              interupt_request,
  output logic              busy,
  output logic              done,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n
);
  localparam int TW = $clog2(2*DATA_W);
  localparam logic [TW-1:0] LAST_TOG = TW'(2*DATA_W-1);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} state_t;
  state_t r_state, w_next;

  logic [11:0]       r_cfg;
  logic [7:0]        r_div_cnt;
  logic [TW-1:0]     r_tog;
  logic [DATA_W-1:0] r_tx_sr, r_rx_sr, r_data;
  logic              r_sclk, r_mosi, r_cs_n, r_busy, r_done, r_irq;
  logic              w_half_end, w_lead, w_sample, w_drive, w_irq_set;
  logic              w_unused_cfg;

  assign w_unused_cfg = ^data_config[CFG_W-1:12];

  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? {1'b0, d[DATA_W-1:1]} : {d[DATA_W-2:0], 1'b0};
  endfunction

  assign w_half_end = (r_div_cnt == r_cfg[7:0]);
  // Odd toggles (r_tog even before increment) are leading edges.
  assign w_lead     = ~r_tog[0];
  assign w_sample   = w_lead ^ r_cfg[9];
  assign w_drive    = r_cfg[9] ? w_lead : (~w_lead && (r_tog != LAST_TOG));
  assign w_irq_set  = (r_state == S_TRAIL) && w_half_end && r_cfg[11];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (trans_en) w_next = S_LEAD;
      S_LEAD:  if (w_half_end) w_next = S_SHIFT;
      S_SHIFT: if (w_half_end && (r_tog == LAST_TOG)) w_next = S_TRAIL;
      S_TRAIL: if (w_half_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg     <= '0;
      r_div_cnt <= '0;
      r_tog     <= '0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_data    <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) r_div_cnt <= '0;
      else                   r_div_cnt <= w_half_end ? '0 : r_div_cnt + 8'd1;
      // A completion set beats a simultaneous clear.
      if (w_irq_set)    r_irq <= 1'b1;
      else if (irq_clr) r_irq <= 1'b0;
      case (r_state)
        S_IDLE: if (trans_en) begin
          r_cfg  <= data_config[11:0];
          r_busy <= 1'b1;
          r_cs_n <= 1'b0;
          r_sclk <= data_config[8];
          r_tog  <= '0;
          if (!data_config[9]) begin
            r_mosi  <= first_bit(i_data, data_config[10]);
            r_tx_sr <= shift_out(i_data, data_config[10]);
          end else begin
            r_tx_sr <= i_data;
          end
        end
        S_SHIFT: if (w_half_end) begin
          r_sclk <= ~r_sclk;
          r_tog  <= r_tog + 1'b1;
          if (w_sample)
            r_rx_sr <= r_cfg[10] ? {spi_miso, r_rx_sr[DATA_W-1:1]}
                                 : {r_rx_sr[DATA_W-2:0], spi_miso};
          if (w_drive) begin
            r_mosi  <= first_bit(r_tx_sr, r_cfg[10]);
            r_tx_sr <= shift_out(r_tx_sr, r_cfg[10]);
          end
        end
        S_TRAIL: if (w_half_end) begin
          r_cs_n <= 1'b1;
          r_data <= r_rx_sr;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_data           = r_data;
  assign interupt_request = r_irq;
  assign busy             = r_busy;
  assign done             = r_done;
  assign spi_sclk         = r_sclk;
  assign spi_mosi         = r_mosi;
  assign spi_cs_n         = r_cs_n;
endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: loopback / slave-model transfers, timing, restart,
// async reset abort and interrupt set/clear priority.
module tb_spi_master_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_data;
  logic [31:0] data_config;
  logic        trans_en, irq_clr;
  logic [7:0]  o_data;
  logic        interupt_request, busy, done, spi_sclk, spi_mosi, spi_cs_n;
  wire         spi_miso;

  logic       loopback;
  logic       slave_bit;
  logic [7:0] slave_sr;
  logic [7:0] cap;
  int         nrise;
  int         nchk = 0;
  int         nerr = 0;
  int         lat, ndone, done_at;

  spi_master_core #(.DATA_W(8), .CFG_W(32)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .data_config(data_config),
    .trans_en(trans_en), .irq_clr(irq_clr), .o_data(o_data),
    .interupt_request(interupt_request), .busy(busy), .done(done),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  assign spi_miso = loopback ? spi_mosi : slave_bit;

  always @(posedge spi_sclk) begin
    cap   = {cap[6:0], spi_mosi};
    nrise = nrise + 1;
  end

  // Slave shifts its next bit out on each falling SCLK.
  always @(negedge spi_sclk) begin
    slave_bit = slave_sr[7];
    slave_sr  = {slave_sr[6:0], 1'b0};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] d, input logic [31:0] cfg);
    i_data      = d;
    data_config = cfg;
    trans_en    = 1'b1;
    @(posedge clk); #1;
    trans_en    = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      cycles++;
      if (done) break;
    end
  endtask

  initial begin
    rst = 1'b1; trans_en = 1'b0; irq_clr = 1'b0; i_data = '0; data_config = '0;
    loopback = 1'b1; slave_bit = 1'b0; slave_sr = '0; cap = '0; nrise = 0;
    #12;
    check("rst_cs_n", spi_cs_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sclk", spi_sclk, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_odata", o_data, 8'h00);
    check("rst_irq", interupt_request, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Mode 0 loopback, DIV=1, IRQ enabled
    cap = '0; nrise = 0;
    start(8'hA5, 32'h0000_0801);
    check("t1_busy", busy, 1'b1);
    check("t1_cs_low", spi_cs_n, 1'b0);
    wait_done(lat);
    check("t1_latency", lat, 36);
    check("t1_odata", o_data, 8'hA5);
    check("t1_irq", interupt_request, 1'b1);
    check("t1_busy_end", busy, 1'b0);
    check("t1_cs_end", spi_cs_n, 1'b1);
    check("t1_mosi_bits", cap, 8'hA5);
    check("t1_sclk_rises", nrise, 8);
    @(posedge clk); #1;
    check("t1_done_pulse", done, 1'b0);
    check("t1_odata_hold", o_data, 8'hA5);
    irq_clr = 1'b1;
    @(posedge clk); #1 irq_clr = 1'b0;
    check("irq_clear", interupt_request, 1'b0);

    // Mode 3, DIV=0, slave sends 0x3C
    loopback = 1'b0; slave_sr = 8'h3C; slave_bit = 1'b0;
    start(8'h00, 32'h0000_0300);
    check("t2_sclk_idle_lead", spi_sclk, 1'b1);
    wait_done(lat);
    check("t2_latency", lat, 18);
    check("t2_odata", o_data, 8'h3C);
    check("t2_irq_off", interupt_request, 1'b0);
    check("t2_sclk_idle", spi_sclk, 1'b1);

    // LSB first loopback, DIV=0
    loopback = 1'b1; cap = '0; nrise = 0;
    start(8'h01, 32'h0000_0400);
    wait_done(lat);
    check("t3_latency", lat, 18);
    check("t3_mosi_bits", cap, 8'h80);
    check("t3_odata", o_data, 8'h01);
    check("t3_sclk_rises", nrise, 8);

    // Ignored strobes mid-transfer, restart in the done cycle
    ndone = 0; done_at = 0;
    start(8'hC3, 32'h0000_0001);
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk); #1;
      trans_en = (c == 4 || c == 19);
      if (c == 4) begin i_data = 8'hFF; data_config = 32'h0000_0400; end
      if (done) begin
        ndone++; done_at = c;
        i_data = 8'h96; data_config = 32'h0000_0001; trans_en = 1'b1;
      end
    end
    check("t4_one_done", ndone, 1);
    check("t4_done_at", done_at, 36);
    check("t4_odata", o_data, 8'hC3);
    @(posedge clk); #1 trans_en = 1'b0;
    check("t4_restart_busy", busy, 1'b1);
    check("t4_restart_cs", spi_cs_n, 1'b0);
    wait_done(lat);
    check("t4_latency2", lat, 36);
    check("t4_odata2", o_data, 8'h96);

    // Async reset mid-SHIFT
    start(8'h3C, 32'h0000_0801);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t5_cs_n", spi_cs_n, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_sclk", spi_sclk, 1'b0);
    check("t5_odata", o_data, 8'h00);
    check("t5_done", done, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    check("t5_no_done", done, 1'b0);
    check("t5_no_irq", interupt_request, 1'b0);
    start(8'h5A, 32'h0000_0801);
    wait_done(lat);
    check("t5_latency", lat, 36);
    check("t5_odata_after", o_data, 8'h5A);
    check("t5_irq", interupt_request, 1'b1);

    // irq_clr coinciding with a new completion: set wins
    start(8'h77, 32'h0000_0801);
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk); #1;
      if (c == 35) irq_clr = 1'b1;
    end
    check("t6_done", done, 1'b1);
    check("t6_irq_set_wins", interupt_request, 1'b1);
    check("t6_odata", o_data, 8'h77);
    @(posedge clk); #1 irq_clr = 1'b0;
    check("t6_irq_cleared", interupt_request, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
